// File: rtl/sap_pkg.sv
// Shared opcode encodings and sequencer state type for the SAP core.
// Pure declarations: no latency and no flow control.
// Backpressure: none; imported by the core and the bench.
package sap_pkg;

    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH_ADDR,
        S_FETCH_INSTR,
        S_EXEC1,
        S_EXEC2,
        S_OUT_WAIT,
        S_HALT
    } state_e;

endpackage

// File: rtl/sap_alu_param.sv
// Add/subtract unit with carry (no-borrow on subtract) and zero flags.
// Latency: purely combinational.
// Backpressure: none.
module sap_alu_param #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a_in,
    input  logic [DATA_W-1:0] b_in,
    input  logic              sub,
    output logic [DATA_W-1:0] result,
    output logic              carry,
    output logic              zero
);

    logic [DATA_W-1:0] b_eff;
    logic [DATA_W:0]   sum;

    // Subtract as A + ~B + 1 so carry out reads as "no borrow".
    always_comb begin
        b_eff = sub ? ~b_in : b_in;
        sum   = {1'b0, a_in} + {1'b0, b_eff} + {{DATA_W{1'b0}}, sub};
    end

    assign result = sum[DATA_W-1:0];
    assign carry  = sum[DATA_W];
    assign zero   = (sum[DATA_W-1:0] == '0);

endmodule

// File: rtl/sap_core_param.sv
// Multi-cycle SAP core: PC/MAR/IR/A/B, flags, on-chip RAM and host load port.
// Latency: 3 cycles per instruction, 4 for memory operands, OUT adds a handshake.
// Backpressure: OUT holds out_valid/out_data and freezes the core until out_ready.
module sap_core_param
    import sap_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              prog_we,
    input  logic [ADDR_W-1:0] prog_addr,
    input  logic [DATA_W-1:0] prog_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy,
    output logic              halted
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int IR_W  = 4 + ADDR_W;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [IR_W-1:0]   ir_q, ir_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic              c_q, c_d;
    logic              z_q, z_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_valid_q, out_valid_d;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] ram_rd;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    logic [DATA_W-1:0] ram_wdata;

    logic [3:0]        opcode;
    logic [ADDR_W-1:0] operand;
    logic [DATA_W-1:0] operand_ext;
    logic [DATA_W-1:0] alu_result;
    logic              alu_carry;
    logic              alu_zero;

    // IR keeps only the opcode and operand fields; the bits between are don't-care.
    assign opcode      = ir_q[IR_W-1 -: 4];
    assign operand     = ir_q[ADDR_W-1:0];
    assign operand_ext = {{(DATA_W-ADDR_W){1'b0}}, operand};
    assign ram_rd      = mem[mar_q];

    sap_alu_param #(.DATA_W(DATA_W)) u_alu (
        .a_in   (a_q),
        .b_in   (ram_rd),
        .sub    (opcode == OP_SUB),
        .result (alu_result),
        .carry  (alu_carry),
        .zero   (alu_zero)
    );

    always_ff @(posedge clk) begin
        if (ram_we) begin
            mem[ram_waddr] <= ram_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pc_q        <= '0;
            mar_q       <= '0;
            ir_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= 1'b0;
            z_q         <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            mar_q       <= mar_d;
            ir_q        <= ir_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            z_q         <= z_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE, S_HALT: begin
                if (start) state_d = S_FETCH_ADDR;
            end
            S_FETCH_ADDR:  state_d = S_FETCH_INSTR;
            S_FETCH_INSTR: state_d = S_EXEC1;
            S_EXEC1: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: state_d = S_EXEC2;
                    OP_OUT:                         state_d = S_OUT_WAIT;
                    OP_HLT:                         state_d = S_HALT;
                    default:                        state_d = S_FETCH_ADDR;
                endcase
            end
            S_EXEC2: state_d = S_FETCH_ADDR;
            S_OUT_WAIT: begin
                if (out_valid_q && out_ready) state_d = S_FETCH_ADDR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        pc_d        = pc_q;
        mar_d       = mar_q;
        ir_d        = ir_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        z_d         = z_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ram_we      = 1'b0;
        ram_waddr   = mar_q;
        ram_wdata   = a_q;

        unique case (state_q)
            S_IDLE, S_HALT: begin
                // A host write coinciding with start lands before the first fetch.
                if (prog_we) begin
                    ram_we    = 1'b1;
                    ram_waddr = prog_addr;
                    ram_wdata = prog_data;
                end
                if (start) pc_d = '0;
            end
            S_FETCH_ADDR: mar_d = pc_q;
            S_FETCH_INSTR: begin
                ir_d = {ram_rd[DATA_W-1 -: 4], ram_rd[ADDR_W-1:0]};
                pc_d = pc_q + ADDR_W'(1);
            end
            S_EXEC1: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA: mar_d = operand;
                    OP_LDI: a_d = operand_ext;
                    OP_JMP: pc_d = operand;
                    OP_JC:  if (c_q) pc_d = operand;
                    OP_JZ:  if (z_q) pc_d = operand;
                    OP_OUT: begin
                        out_data_d  = a_q;
                        out_valid_d = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_EXEC2: begin
                case (opcode)
                    OP_LDA: a_d = ram_rd;
                    OP_ADD, OP_SUB: begin
                        b_d = ram_rd;
                        a_d = alu_result;
                        c_d = alu_carry;
                        z_d = alu_zero;
                    end
                    OP_STA: ram_we = 1'b1;
                    default: ;
                endcase
            end
            S_OUT_WAIT: begin
                if (out_valid_q && out_ready) out_valid_d = 1'b0;
            end
            default: ;
        endcase
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_HALT);
    assign halted    = (state_q == S_HALT);

endmodule
